// File: rtl/rob_ctrl_pkg.sv
// Shared widths, FSM encodings and the writeback payload for the reorder-buffer controller.
package rob_ctrl_pkg;

    localparam int unsigned ROB_IDX_W = 3;
    localparam int unsigned ROB_DEPTH = 2 ** ROB_IDX_W;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned RD_W      = 5;

    localparam logic [0:0] ROB_RUN   = 1'b0;
    localparam logic [0:0] ROB_FLUSH = 1'b1;

    typedef struct packed {
        logic            mispredict;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] data;
    } rob_wb_t;

endpackage

// File: rtl/rob_entry_array.sv
// ROB entry storage: dispatch and writeback write ports, clear-all, head read port and two lookup ports.
module rob_entry_array
    import rob_ctrl_pkg::*;
#(
    parameter int unsigned IW = ROB_IDX_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clear,
    input  logic            i_disp_we,
    input  logic [IW-1:0]   i_disp_idx,
    input  logic [RD_W-1:0] i_disp_rd,
    input  logic            i_wb_we,
    input  logic [IW-1:0]   i_wb_idx,
    input  rob_wb_t         i_wb,
    input  logic            i_retire,
    input  logic [IW-1:0]   i_head_idx,
    output logic            o_head_busy,
    output logic            o_head_done,
    output logic [RD_W-1:0] o_head_rd,
    output rob_wb_t         o_head_wb,
    input  logic [IW-1:0]   i_q_idx1,
    input  logic [IW-1:0]   i_q_idx2,
    output logic            o_q_ready1,
    output logic            o_q_ready2,
    output logic [XLEN-1:0] o_q_data1,
    output logic [XLEN-1:0] o_q_data2
);

    localparam int unsigned DEPTH = 2 ** IW;

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] r_done;
    logic [RD_W-1:0]  r_rd [DEPTH];
    rob_wb_t          r_wb [DEPTH];
    logic             w_wb_acc;

    // A writeback lands only on a live entry that is not being reallocated this cycle.
    assign w_wb_acc = i_wb_we && r_busy[i_wb_idx] && !(i_disp_we && (i_disp_idx == i_wb_idx));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
            r_done <= '0;
        end else if (i_clear) begin
            r_busy <= '0;
            r_done <= '0;
        end else begin
            if (i_retire) r_busy[i_head_idx] <= 1'b0;
            if (w_wb_acc) r_done[i_wb_idx] <= 1'b1;
            if (i_disp_we) begin
                r_busy[i_disp_idx] <= 1'b1;
                r_done[i_disp_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_disp_we) r_rd[i_disp_idx] <= i_disp_rd;
        if (w_wb_acc)  r_wb[i_wb_idx]   <= i_wb;
    end

    assign o_head_busy = r_busy[i_head_idx];
    assign o_head_done = r_done[i_head_idx];
    assign o_head_rd   = r_rd[i_head_idx];
    assign o_head_wb   = r_wb[i_head_idx];

    assign o_q_ready1 = r_busy[i_q_idx1] && r_done[i_q_idx1];
    assign o_q_ready2 = r_busy[i_q_idx2] && r_done[i_q_idx2];
    assign o_q_data1  = o_q_ready1 ? r_wb[i_q_idx1].data : '0;
    assign o_q_data2  = o_q_ready2 ? r_wb[i_q_idx2].data : '0;

endmodule

// File: rtl/rob_ctrl.sv
// In-order retirement controller: allocates ROB entries, retires to the RAT and flushes on a mispredicted branch.
module rob_ctrl
    import rob_ctrl_pkg::*;
#(
    parameter int unsigned ROB_ENTRY_WIDTH = ROB_IDX_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [RD_W-1:0]            disp_rd,
    output logic [ROB_ENTRY_WIDTH-1:0] disp_index,
    output logic                       dec_we,
    input  logic                       wb_valid,
    input  logic [ROB_ENTRY_WIDTH-1:0] wb_index,
    input  logic [XLEN-1:0]            wb_data,
    input  logic                       wb_mispredict,
    input  logic [XLEN-1:0]            wb_target,
    input  logic [ROB_ENTRY_WIDTH-1:0] q_index1,
    input  logic [ROB_ENTRY_WIDTH-1:0] q_index2,
    output logic                       q_ready1,
    output logic                       q_ready2,
    output logic [XLEN-1:0]            q_data1,
    output logic [XLEN-1:0]            q_data2,
    output logic                       commit_we,
    output logic [RD_W-1:0]            commit_rd,
    output logic [XLEN-1:0]            commit_data,
    output logic [ROB_ENTRY_WIDTH-1:0] commit_index,
    output logic                       commit_retire,
    output logic                       rollback,
    output logic                       redirect_valid,
    output logic [XLEN-1:0]            redirect_pc,
    output logic                       rob_empty,
    output logic [ROB_ENTRY_WIDTH:0]   rob_count
);

    localparam int unsigned IW = ROB_ENTRY_WIDTH;
    localparam int unsigned PW = ROB_ENTRY_WIDTH + 1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [XLEN-1:0] r_redirect_pc;

    logic            w_full;
    logic            w_run;
    logic            w_disp_fire;
    logic            w_retire;
    logic            w_head_busy;
    logic            w_head_done;
    logic [RD_W-1:0] w_head_rd;
    rob_wb_t         w_head_wb;
    rob_wb_t         w_wb;
    logic            w_arr_ready1;
    logic            w_arr_ready2;
    logic [XLEN-1:0] w_arr_data1;
    logic [XLEN-1:0] w_arr_data2;

    assign w_full = (r_head[IW-1:0] == r_tail[IW-1:0]) && (r_head[IW] != r_tail[IW]);
    assign w_wb   = '{mispredict: wb_mispredict, target: wb_target, data: wb_data};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ROB_RUN;
        else      r_state <= w_state_nxt;
    end

    // Next state and state-decoded controls; a mispredicted head retires and then flushes for one cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_run          = 1'b0;
        rollback       = 1'b0;
        redirect_valid = 1'b0;
        w_retire       = 1'b0;
        case (r_state)
            ROB_RUN: begin
                w_run    = 1'b1;
                w_retire = w_head_busy && w_head_done;
                if (w_retire && w_head_wb.mispredict) w_state_nxt = ROB_FLUSH;
            end
            ROB_FLUSH: begin
                rollback       = 1'b1;
                redirect_valid = 1'b1;
                w_state_nxt    = ROB_RUN;
            end
            default: w_state_nxt = ROB_RUN;
        endcase
    end

    assign disp_ready  = w_run && !w_full;
    assign w_disp_fire = disp_valid && disp_ready;
    assign disp_index  = r_tail[IW-1:0];
    assign dec_we      = w_disp_fire && (disp_rd != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_redirect_pc <= '0;
        end else if (r_state == ROB_FLUSH) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_disp_fire) r_tail <= r_tail + PW'(1);
            if (w_retire)    r_head <= r_head + PW'(1);
            if (w_retire && w_head_wb.mispredict) r_redirect_pc <= w_head_wb.target;
        end
    end

    assign redirect_pc   = r_redirect_pc;
    assign rob_count     = r_tail - r_head;
    assign rob_empty     = (r_tail == r_head);
    assign commit_retire = w_retire;
    assign commit_we     = w_retire && (w_head_rd != '0);
    assign commit_rd     = w_retire ? w_head_rd : '0;
    assign commit_data   = w_retire ? w_head_wb.data : '0;
    assign commit_index  = w_retire ? r_head[IW-1:0] : '0;

    // CDB bypass takes priority over stored results.
    always_comb begin
        q_ready1 = w_arr_ready1;
        q_data1  = w_arr_data1;
        q_ready2 = w_arr_ready2;
        q_data2  = w_arr_data2;
        if (wb_valid && (wb_index == q_index1)) begin
            q_ready1 = 1'b1;
            q_data1  = wb_data;
        end
        if (wb_valid && (wb_index == q_index2)) begin
            q_ready2 = 1'b1;
            q_data2  = wb_data;
        end
    end

    rob_entry_array #(.IW(IW)) u_entries (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (r_state == ROB_FLUSH),
        .i_disp_we   (w_disp_fire),
        .i_disp_idx  (r_tail[IW-1:0]),
        .i_disp_rd   (disp_rd),
        .i_wb_we     (wb_valid && w_run),
        .i_wb_idx    (wb_index),
        .i_wb        (w_wb),
        .i_retire    (w_retire),
        .i_head_idx  (r_head[IW-1:0]),
        .o_head_busy (w_head_busy),
        .o_head_done (w_head_done),
        .o_head_rd   (w_head_rd),
        .o_head_wb   (w_head_wb),
        .i_q_idx1    (q_index1),
        .i_q_idx2    (q_index2),
        .o_q_ready1  (w_arr_ready1),
        .o_q_ready2  (w_arr_ready2),
        .o_q_data1   (w_arr_data1),
        .o_q_data2   (w_arr_data2)
    );

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed bench for rob_ctrl: inputs change on the falling edge, outputs are sampled 1 ns later.
module tb_rob_ctrl;

    logic        clk;
    logic        rst;
    logic        disp_valid;
    logic        disp_ready;
    logic [4:0]  disp_rd;
    logic [2:0]  disp_index;
    logic        dec_we;
    logic        wb_valid;
    logic [2:0]  wb_index;
    logic [31:0] wb_data;
    logic        wb_mispredict;
    logic [31:0] wb_target;
    logic [2:0]  q_index1;
    logic [2:0]  q_index2;
    logic        q_ready1;
    logic        q_ready2;
    logic [31:0] q_data1;
    logic [31:0] q_data2;
    logic        commit_we;
    logic [4:0]  commit_rd;
    logic [31:0] commit_data;
    logic [2:0]  commit_index;
    logic        commit_retire;
    logic        rollback;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        rob_empty;
    logic [3:0]  rob_count;

    int n_checks = 0;
    int n_fail   = 0;

    rob_ctrl dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rd(disp_rd),
        .disp_index(disp_index), .dec_we(dec_we),
        .wb_valid(wb_valid), .wb_index(wb_index), .wb_data(wb_data),
        .wb_mispredict(wb_mispredict), .wb_target(wb_target),
        .q_index1(q_index1), .q_index2(q_index2),
        .q_ready1(q_ready1), .q_ready2(q_ready2), .q_data1(q_data1), .q_data2(q_data2),
        .commit_we(commit_we), .commit_rd(commit_rd), .commit_data(commit_data),
        .commit_index(commit_index), .commit_retire(commit_retire),
        .rollback(rollback), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .rob_empty(rob_empty), .rob_count(rob_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge with all strobes idle.
    task automatic nxt();
        @(negedge clk);
        disp_valid    = 1'b0;
        wb_valid      = 1'b0;
        wb_mispredict = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        disp_valid = 1'b0;
        wb_valid   = 1'b0;
        rst        = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic dispatch(input logic [4:0] rd);
        nxt();
        disp_valid = 1'b1;
        disp_rd    = rd;
    endtask

    task automatic writeback(input logic [2:0] idx, input logic [31:0] data);
        nxt();
        wb_valid = 1'b1;
        wb_index = idx;
        wb_data  = data;
    endtask

    initial begin
        rst = 1'b0; disp_valid = 1'b0; disp_rd = '0;
        wb_valid = 1'b0; wb_index = '0; wb_data = '0; wb_mispredict = 1'b0; wb_target = '0;
        q_index1 = '0; q_index2 = '0;

        #1;
        check("rst_count", 32'(rob_count), 32'd0);
        check("rst_empty", 32'(rob_empty), 32'd1);
        check("rst_ready", 32'(disp_ready), 32'd1);
        check("rst_rollback", 32'(rollback), 32'd0);
        check("rst_redir", 32'(redirect_valid), 32'd0);
        check("rst_redir_pc", redirect_pc, 32'd0);
        check("rst_commit_we", 32'(commit_we), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Single dispatch, writeback and commit
        dispatch(5'd5); #1;
        check("t1_disp_index", 32'(disp_index), 32'd0);
        check("t1_dec_we", 32'(dec_we), 32'd1);
        writeback(3'd0, 32'h1234); #1;
        check("t1_no_early_commit", 32'(commit_retire), 32'd0);
        nxt(); #1;
        check("t1_commit_we", 32'(commit_we), 32'd1);
        check("t1_commit_rd", 32'(commit_rd), 32'd5);
        check("t1_commit_data", commit_data, 32'h1234);
        check("t1_commit_index", 32'(commit_index), 32'd0);
        nxt(); #1;
        check("t1_empty", 32'(rob_empty), 32'd1);

        // Fill, commit at full, then wrap
        do_reset();
        for (int i = 0; i < 8; i++) begin
            dispatch(5'(i + 1)); #1;
            check("t2_disp_index", 32'(disp_index), 32'(i));
        end
        dispatch(5'd20); #1;
        check("t2_count_full", 32'(rob_count), 32'd8);
        check("t2_ready_full", 32'(disp_ready), 32'd0);
        check("t2_dec_we_stall", 32'(dec_we), 32'd0);
        writeback(3'd0, 32'hA0);
        disp_valid = 1'b1; #1;
        check("t2_ready_wb", 32'(disp_ready), 32'd0);
        dispatch(5'd21); #1;
        check("t2_commit_full", 32'(commit_retire), 32'd1);
        check("t2_commit_rd", 32'(commit_rd), 32'd1);
        check("t2_ready_commit", 32'(disp_ready), 32'd0);
        dispatch(5'd9); #1;
        check("t2_ready_after", 32'(disp_ready), 32'd1);
        check("t2_wrap_index", 32'(disp_index), 32'd0);

        // Out-of-order completion retires in order
        do_reset();
        dispatch(5'd10);
        dispatch(5'd11);
        dispatch(5'd12);
        writeback(3'd2, 32'h22); #1;
        check("t3_hold0", 32'(commit_retire), 32'd0);
        writeback(3'd1, 32'h11);
        q_index1 = 3'd2; q_index2 = 3'd0; #1;
        check("t3_hold1", 32'(commit_retire), 32'd0);
        check("t3_q1_ready", 32'(q_ready1), 32'd1);
        check("t3_q1_data", q_data1, 32'h22);
        check("t3_q2_ready", 32'(q_ready2), 32'd0);
        check("t3_q2_data", q_data2, 32'd0);
        writeback(3'd0, 32'h10); #1;
        check("t3_hold2", 32'(commit_retire), 32'd0);
        nxt(); #1;
        check("t3_c0_index", 32'(commit_index), 32'd0);
        check("t3_c0_data", commit_data, 32'h10);
        nxt(); #1;
        check("t3_c1_index", 32'(commit_index), 32'd1);
        check("t3_c1_rd", 32'(commit_rd), 32'd11);
        nxt(); #1;
        check("t3_c2_index", 32'(commit_index), 32'd2);
        check("t3_c2_data", commit_data, 32'h22);
        nxt(); #1;
        check("t3_empty", 32'(rob_empty), 32'd1);

        // rd=0 retires without a RAT write
        dispatch(5'd0); #1;
        check("t4_dec_we", 32'(dec_we), 32'd0);
        check("t4_disp_index", 32'(disp_index), 32'd3);
        writeback(3'd3, 32'h55);
        nxt(); #1;
        check("t4_retire", 32'(commit_retire), 32'd1);
        check("t4_commit_we", 32'(commit_we), 32'd0);
        check("t4_commit_index", 32'(commit_index), 32'd3);

        // Mispredicted branch at index 1
        do_reset();
        dispatch(5'd1);
        dispatch(5'd2);
        dispatch(5'd3);
        writeback(3'd0, 32'd1);
        writeback(3'd1, 32'd2);
        wb_mispredict = 1'b1; wb_target = 32'h80;
        dispatch(5'd7); #1;
        check("t5_br_commit_we", 32'(commit_we), 32'd1);
        check("t5_br_index", 32'(commit_index), 32'd1);
        check("t5_br_no_rollback", 32'(rollback), 32'd0);
        writeback(3'd2, 32'h99); #1;
        check("t5_rollback", 32'(rollback), 32'd1);
        check("t5_redir_valid", 32'(redirect_valid), 32'd1);
        check("t5_redir_pc", redirect_pc, 32'h80);
        check("t5_flush_ready", 32'(disp_ready), 32'd0);
        check("t5_flush_retire", 32'(commit_retire), 32'd0);
        nxt();
        q_index1 = 3'd2; #1;
        check("t5_count", 32'(rob_count), 32'd0);
        check("t5_disp_index", 32'(disp_index), 32'd0);
        check("t5_rollback_off", 32'(rollback), 32'd0);
        check("t5_q_flushed", 32'(q_ready1), 32'd0);

        // CDB bypass, then asynchronous reset with entries in flight
        do_reset();
        dispatch(5'd1);
        dispatch(5'd2);
        dispatch(5'd3);
        dispatch(5'd4);
        writeback(3'd3, 32'hBEEF);
        q_index1 = 3'd3; #1;
        check("t6_bypass_ready", 32'(q_ready1), 32'd1);
        check("t6_bypass_data", q_data1, 32'hBEEF);
        check("t6_count", 32'(rob_count), 32'd4);
        #1 rst = 1'b0;
        #1;
        check("t6_rst_count", 32'(rob_count), 32'd0);
        check("t6_rst_rollback", 32'(rollback), 32'd0);
        check("t6_rst_empty", 32'(rob_empty), 32'd1);
        nxt();
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
